jpeg_segment_sequencer: RTL and testbench
=========================================

Name: jpeg_segment_sequencer

Overview:
- Front-end controller for the JPEG header path; sits between the 32-bit raw word stream and the table loaders (DQT, DHT, SOF0, SOS).
- Unpacks words into bytes, big-endian (bits [31:24] first), and locates SOI and segment markers.
- Reads each segment's length and routes its payload to the right loader, tagged with a type code, under valid/ready flow control.
- Asserts hdr_done once the SOS payload is delivered, then stops consuming input.

Parameters:
- STRICT_SOI, 1: when 1, the first two bytes must be FF D8, else ERROR. When 0, bytes are discarded until FF D8 is found.
- SKIP_UNKNOWN, 1: when 1, APPn (n≠0), COM and DRI segments are skipped by length. When 0, they cause ERROR.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- data_in, in, 32: raw JPEG word; byte order [31:24],[23:16],[15:8],[7:0].
- in_valid, in, 1: data_in valid.
- in_ready, out, 1: word accepted on clk when in_valid && in_ready.
- seg_byte, out, 8: payload byte.
- seg_type, out, 3: 1=APP0, 2=DQT, 3=DHT, 4=SOF0, 5=SOS (jseg_t).
- seg_valid, out, 1: seg_byte/seg_type valid.
- seg_ready, in, 1: consumer accepts the byte.
- seg_last, out, 1: final payload byte of the segment.
- jpeg_valid, out, 1: sticky; SOI found.
- found_app0, out, 1: sticky; APP0 marker found.
- hdr_done, out, 1: sticky; SOS payload fully delivered.
- err, out, 1: sticky; protocol error.
- err_code, out, 3: 1=no SOI, 2=len<2, 3=unsupported SOF, 4=EOI before SOS, 5=unknown marker with SKIP_UNKNOWN=0.

Behaviour:
- Reset:
  - All outputs 0; seg_type is 0.
  - Byte buffer is emptied; FSM goes to SOI0.
  - Asserting rst mid-segment aborts immediately; sticky flags clear.
- Unpacker:
  - One-word buffer with a 2-bit byte index.
  - in_ready = buffer empty, OR (index==3 and the current byte is consumed this cycle). This gives back-to-back words without a bubble.
  - At most one byte is consumed per cycle.
  - In PAYLOAD, a byte is consumed only on seg_valid && seg_ready. In all other states, any buffered byte is consumed.
- FSM states: SOI0, SOI1, SEEK_FF, MARKER, LEN_HI, LEN_LO, PAYLOAD, SKIP, DONE, ERROR.
- SOI0:
  - FF → SOI1.
  - Else: ERROR(1) if STRICT_SOI, otherwise stay.
- SOI1:
  - D8 → set jpeg_valid, go to SEEK_FF.
  - FF → stay.
  - Else: ERROR(1) if STRICT_SOI, otherwise SOI0.
- SEEK_FF: FF → MARKER; other bytes are discarded.
- MARKER (byte after FF):
  - FF: fill byte, stay.
  - 00, D0–D7, 01: ignored → SEEK_FF.
  - E0: set found_app0, type APP0.
  - DB → DQT; C4 → DHT; C0 → SOF0; DA → SOS. Each → LEN_HI with type latched.
  - C1–C3, C5–C7, C9–CB, CD–CF → ERROR(3).
  - D9 → ERROR(4).
  - Other: LEN_HI with a skip flag if SKIP_UNKNOWN, else ERROR(5).
- LEN_HI, LEN_LO:
  - Assemble a 16-bit length L.
  - L<2 → ERROR(2).
  - L==2: segment is empty, no bytes are emitted; SOS → DONE, else → SEEK_FF.
  - Otherwise a 16-bit counter is loaded with L-2 and the FSM goes to PAYLOAD, or to SKIP if the skip flag is set.
- PAYLOAD:
  - seg_valid = buffer valid. seg_byte, seg_type and seg_last come combinationally from the buffer, type register and counter.
  - seg_last = (counter==1).
  - Counter decrements on each handshake.
  - After the last handshake: SOS → DONE, else → SEEK_FF.
  - Holding seg_ready=0 stalls everything, and in_ready deasserts once the buffer is full.
- SKIP: drain the counter with no output, then → SEEK_FF.
- DONE:
  - hdr_done=1 from the cycle after the last SOS handshake.
  - in_ready=0 and no further consumption; the remaining buffered bytes are retained, reserved for the entropy stage.
- ERROR: err=1, in_ready=0, seg_valid=0 until rst.

Decomposition:
- Package jpeg_pkg:
  - jseg_t enum for segment types.
  - Marker constants: M_SOI=8'hD8, M_EOI, M_APP0, M_DQT, M_DHT, M_SOF0, M_SOS.
  - err_code localparams.
  - Sequencer FSM state enum.
- Sub-module jpeg_byte_unpacker: word buffer, byte index and in_ready logic; byte valid/ready interface to the FSM.

Test Plan:
- Words FFD8FFE0, 0004AABB, FFDB0003, 07FFDA00, 0301...; seg_ready=1 → jpeg_valid and found_app0 set.
  - APP0 bytes AA, BB with seg_last on BB.
  - DQT byte 07 with seg_type=2 and seg_last.
  - SOS byte 01 tagged 5 with seg_last; hdr_done the next cycle.
- First word 12345678 with STRICT_SOI=1 → err=1, err_code=1, in_ready=0.
- FF FF FF DB fill bytes before the marker → treated as a single DQT marker, no error.
- APP1 segment FFE1 0005 112233 with SKIP_UNKNOWN=1 → no seg_valid for those bytes; the next DHT payload is tagged 3.
- seg_ready toggled 0/1 every other cycle over a 6-byte DHT payload → all 6 bytes delivered in order; counter and seg_last correct; in_valid words not dropped.
- FFC2 marker → err_code=3. Separately, FFD9 before SOS → err_code=4. Separately, rst asserted mid-PAYLOAD → all outputs 0 the next cycle, and a fresh SOI is detected.

Source files
------------

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared types and constants for the JPEG header front end.
//   jseg_t       - payload type tag presented to the table loaders
//   M_*          - marker second-byte values
//   ERR_*        - err_code values
//   seq_state_t  - sequencer FSM states (also exported on dbg_state)
//   is_standalone / is_unsupported_sof - marker classification helpers
package jpeg_pkg;

  typedef enum logic [2:0] {
    SEG_NONE = 3'd0,
    SEG_APP0 = 3'd1,
    SEG_DQT  = 3'd2,
    SEG_DHT  = 3'd3,
    SEG_SOF0 = 3'd4,
    SEG_SOS  = 3'd5
  } jseg_t;

  localparam logic [7:0] M_FILL = 8'hFF;
  localparam logic [7:0] M_SOI  = 8'hD8;
  localparam logic [7:0] M_EOI  = 8'hD9;
  localparam logic [7:0] M_APP0 = 8'hE0;
  localparam logic [7:0] M_DQT  = 8'hDB;
  localparam logic [7:0] M_DHT  = 8'hC4;
  localparam logic [7:0] M_SOF0 = 8'hC0;
  localparam logic [7:0] M_SOS  = 8'hDA;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_NO_SOI  = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_SOF     = 3'd3;
  localparam logic [2:0] ERR_EOI     = 3'd4;
  localparam logic [2:0] ERR_UNKNOWN = 3'd5;

  typedef enum logic [3:0] {
    ST_SOI0    = 4'd0,
    ST_SOI1    = 4'd1,
    ST_SEEK_FF = 4'd2,
    ST_MARKER  = 4'd3,
    ST_LEN_HI  = 4'd4,
    ST_LEN_LO  = 4'd5,
    ST_PAYLOAD = 4'd6,
    ST_SKIP    = 4'd7,
    ST_DONE    = 4'd8,
    ST_ERROR   = 4'd9
  } seq_state_t;

  // Markers with no length field: stuffing (00), TEM (01), RST0-7 (D0-D7).
  function automatic logic is_standalone(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'h01) || (b[7:3] == 5'b11010);
  endfunction

  // SOF1-3, 5-7, 9-B, D-F: every Cx whose low two bits are nonzero.
  function automatic logic is_unsupported_sof(input logic [7:0] b);
    return (b[7:4] == 4'hC) && (b[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/jpeg_byte_unpacker.sv
// jpeg_byte_unpacker: one-word buffer that splits 32-bit words into bytes,
// most significant byte first.
//   clk, rst            - clock, synchronous active-high reset
//   data_in, in_valid   - word input
//   in_ready            - word accepted when in_valid && in_ready
//   accept_en           - sequencer permission to take new words
//   byte_data, byte_valid, byte_ready - byte stream toward the sequencer
//
// Handshake: a transfer happens on a rising clk edge when valid && ready are
// both high; valid never depends on ready, data is stable while valid is high
// and not accepted.
module jpeg_byte_unpacker (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        accept_en,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready
);

  logic [31:0] buf_q, buf_d;
  logic [1:0]  idx_q, idx_d;
  logic        full_q, full_d;
  logic        consume;

  assign byte_valid = full_q;
  assign consume    = full_q && byte_ready;
  // Refill in the same cycle the last byte leaves, so words stream back to back.
  assign in_ready   = accept_en && (!full_q || (idx_q == 2'd3 && consume));

  always_comb begin
    byte_data = 8'h00;
    case (idx_q)
      2'd0:    byte_data = buf_q[31:24];
      2'd1:    byte_data = buf_q[23:16];
      2'd2:    byte_data = buf_q[15:8];
      default: byte_data = buf_q[7:0];
    endcase
  end

  always_comb begin
    buf_d  = buf_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (in_valid && in_ready) begin
      buf_d  = data_in;
      idx_d  = 2'd0;
      full_d = 1'b1;
    end else if (consume) begin
      if (idx_q == 2'd3) full_d = 1'b0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= 32'h0;
      idx_q  <= 2'd0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/jpeg_segment_sequencer.sv
// jpeg_segment_sequencer: JPEG header front end. Finds SOI, walks the marker
// segments and forwards DQT/DHT/SOF0/SOS/APP0 payload bytes to the loaders.
//   clk, rst                     - clock, synchronous active-high reset
//   data_in, in_valid, in_ready  - 32-bit raw stream, big-endian bytes
//   seg_byte, seg_type, seg_last - payload byte, jseg_t tag, final-byte flag
//   seg_valid, seg_ready         - payload handshake
//   jpeg_valid, found_app0       - sticky: SOI seen, APP0 seen
//   hdr_done                     - sticky: SOS payload delivered
//   err, err_code                - sticky protocol error and its cause
//   dbg_state                    - current sequencer state
module jpeg_segment_sequencer
  import jpeg_pkg::*;
#(
  parameter bit STRICT_SOI   = 1'b1,
  parameter bit SKIP_UNKNOWN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  seg_byte,
  output logic [2:0]  seg_type,
  output logic        seg_valid,
  input  logic        seg_ready,
  output logic        seg_last,
  output logic        jpeg_valid,
  output logic        found_app0,
  output logic        hdr_done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [3:0]  dbg_state
);

  seq_state_t  state_q, state_d;
  jseg_t       type_q, type_d;
  logic        skip_q, skip_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] cnt_q, cnt_d;
  logic        jpeg_valid_q, jpeg_valid_d;
  logic        found_app0_q, found_app0_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [15:0] len_w;

  logic [7:0]  ub_byte;
  logic        ub_valid;
  logic        ub_ready;
  logic        accept_en;

  jpeg_byte_unpacker u_unpacker (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .accept_en  (accept_en),
    .byte_data  (ub_byte),
    .byte_valid (ub_valid),
    .byte_ready (ub_ready)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SOI0;
      type_q       <= SEG_NONE;
      skip_q       <= 1'b0;
      len_hi_q     <= 8'h00;
      cnt_q        <= 16'h0;
      jpeg_valid_q <= 1'b0;
      found_app0_q <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      skip_q       <= skip_d;
      len_hi_q     <= len_hi_d;
      cnt_q        <= cnt_d;
      jpeg_valid_q <= jpeg_valid_d;
      found_app0_q <= found_app0_d;
      err_code_q   <= err_code_d;
    end
  end

  // Next-state and datapath. Every transition needs a buffered byte; in
  // PAYLOAD it additionally needs the consumer to take it.
  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    skip_d       = skip_q;
    len_hi_d     = len_hi_q;
    cnt_d        = cnt_q;
    jpeg_valid_d = jpeg_valid_q;
    found_app0_d = found_app0_q;
    err_code_d   = err_code_q;
    len_w        = {len_hi_q, ub_byte};
    if (ub_valid) begin
      case (state_q)
        ST_SOI0: begin
          if (ub_byte == M_FILL) begin
            state_d = ST_SOI1;
          end else if (STRICT_SOI) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_NO_SOI;
          end
        end
        ST_SOI1: begin
          if (ub_byte == M_SOI) begin
            jpeg_valid_d = 1'b1;
            state_d      = ST_SEEK_FF;
          end else if (ub_byte != M_FILL) begin
            if (STRICT_SOI) begin
              state_d    = ST_ERROR;
              err_code_d = ERR_NO_SOI;
            end else begin
              state_d = ST_SOI0;
            end
          end
        end
        ST_SEEK_FF: begin
          if (ub_byte == M_FILL) state_d = ST_MARKER;
        end
        ST_MARKER: begin
          skip_d = 1'b0;
          if (ub_byte == M_FILL) begin
            state_d = ST_MARKER;               // fill byte before the marker code
          end else if (is_standalone(ub_byte)) begin
            state_d = ST_SEEK_FF;
          end else if (ub_byte == M_APP0) begin
            found_app0_d = 1'b1;
            type_d       = SEG_APP0;
            state_d      = ST_LEN_HI;
          end else if (ub_byte == M_DQT) begin
            type_d  = SEG_DQT;
            state_d = ST_LEN_HI;
          end else if (ub_byte == M_DHT) begin
            type_d  = SEG_DHT;
            state_d = ST_LEN_HI;
          end else if (ub_byte == M_SOF0) begin
            type_d  = SEG_SOF0;
            state_d = ST_LEN_HI;
          end else if (ub_byte == M_SOS) begin
            type_d  = SEG_SOS;
            state_d = ST_LEN_HI;
          end else if (is_unsupported_sof(ub_byte)) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_SOF;
          end else if (ub_byte == M_EOI) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_EOI;
          end else if (SKIP_UNKNOWN) begin
            type_d  = SEG_NONE;
            skip_d  = 1'b1;
            state_d = ST_LEN_HI;
          end else begin
            state_d    = ST_ERROR;
            err_code_d = ERR_UNKNOWN;
          end
        end
        ST_LEN_HI: begin
          len_hi_d = ub_byte;
          state_d  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          // The length field counts its own two bytes.
          if (len_w < 16'd2) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_LEN;
          end else if (len_w == 16'd2) begin
            state_d = (type_q == SEG_SOS && !skip_q) ? ST_DONE : ST_SEEK_FF;
          end else begin
            cnt_d   = len_w - 16'd2;
            state_d = skip_q ? ST_SKIP : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (seg_ready) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = (type_q == SEG_SOS) ? ST_DONE : ST_SEEK_FF;
          end
        end
        ST_SKIP: begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_SEEK_FF;
        end
        default: ;
      endcase
    end
  end

  // Outputs. DONE leaves the rest of the buffered word untouched for the
  // entropy stage, so neither DONE nor ERROR consumes or accepts anything.
  always_comb begin
    seg_valid  = 1'b0;
    seg_byte   = 8'h00;
    seg_type   = SEG_NONE;
    seg_last   = 1'b0;
    ub_ready   = 1'b1;
    accept_en  = !rst;
    if (state_q == ST_PAYLOAD) begin
      seg_valid = ub_valid;
      seg_byte  = ub_byte;
      seg_type  = type_q;
      seg_last  = (cnt_q == 16'd1);
      ub_ready  = seg_ready;
    end else if (state_q == ST_DONE || state_q == ST_ERROR) begin
      ub_ready  = 1'b0;
      accept_en = 1'b0;
    end
    jpeg_valid = jpeg_valid_q;
    found_app0 = found_app0_q;
    hdr_done   = (state_q == ST_DONE);
    err        = (state_q == ST_ERROR);
    err_code   = err_code_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_jpeg_segment_sequencer.sv
// tb_jpeg_segment_sequencer: directed vectors for jpeg_segment_sequencer.
module tb_jpeg_segment_sequencer;
  import jpeg_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] data_in = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  seg_byte;
  logic [2:0]  seg_type;
  logic        seg_valid;
  logic        seg_ready = 1'b0;
  logic        seg_last;
  logic        jpeg_valid, found_app0, hdr_done, err;
  logic [2:0]  err_code;
  logic [3:0]  dbg_state;

  jpeg_segment_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .seg_byte   (seg_byte),
    .seg_type   (seg_type),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .seg_last   (seg_last),
    .jpeg_valid (jpeg_valid),
    .found_app0 (found_app0),
    .hdr_done   (hdr_done),
    .err        (err),
    .err_code   (err_code),
    .dbg_state  (dbg_state)
  );

  // scoreboard state
  logic [31:0] word_q[$];
  logic [11:0] exp_q[$];          // {type, last, byte}
  int          n_vec = 0;
  int          n_err = 0;
  int          rdy_mode = 0;      // 0: always ready, 1: toggle, 2: never ready
  int          cyc = 0;
  bit          done_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] t, input logic l, input logic [7:0] b);
    exp_q.push_back({t, l, b});
  endtask

  // One cycle: drive at the falling edge, sample 1ns later; the sampled
  // values are what the next rising edge will act on.
  task automatic step();
    logic [11:0] e;
    @(negedge clk);
    in_valid = (word_q.size() != 0);
    data_in  = in_valid ? word_q[0] : 32'h0;
    case (rdy_mode)
      0:       seg_ready = 1'b1;
      1:       seg_ready = cyc[0];
      default: seg_ready = 1'b0;
    endcase
    cyc++;
    #1;
    if (done_pending) begin
      check("hdr_done_next", hdr_done, 1);
      done_pending = 1'b0;
    end
    if (in_valid && in_ready) void'(word_q.pop_front());
    if (seg_valid && seg_ready) begin
      check("seg_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("seg_beat", {seg_type, seg_last, seg_byte}, e);
        if (e[11:9] == 3'd5 && e[8]) begin
          check("hdr_done_early", hdr_done, 0);
          done_pending = 1'b1;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_done(input string tag, input int max);
    int n = 0;
    while (!hdr_done && n < max) begin
      step();
      n++;
    end
    check(tag, hdr_done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {in_ready, seg_valid, seg_byte, seg_type, seg_last, jpeg_valid,
                found_app0, hdr_done, err, err_code}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    word_q.delete();
    exp_q.delete();
    done_pending = 1'b0;
    rdy_mode = 0;
    run(2);
    check_all_zero("reset_outputs");
    rst = 1'b0;
  endtask

  initial begin
    // 1: APP0, DQT, SOS walk-through
    do_reset();
    word_q = '{32'hFFD8FFE0, 32'h0004AABB, 32'hFFDB0003, 32'h07FFDA00, 32'h03010000};
    push_exp(3'd1, 1'b0, 8'hAA);
    push_exp(3'd1, 1'b1, 8'hBB);
    push_exp(3'd2, 1'b1, 8'h07);
    push_exp(3'd5, 1'b1, 8'h01);
    run_until_done("t1_done", 60);
    check("t1_exp_drained", exp_q.size(), 0);
    check("t1_jpeg_valid", jpeg_valid, 1);
    check("t1_found_app0", found_app0, 1);
    check("t1_err", err, 0);
    run(3);
    check("t1_in_ready_done", in_ready, 0);
    check("t1_state_done", dbg_state, 4'd8);

    // 2: bad first word under strict SOI
    do_reset();
    word_q = '{32'h12345678};
    run(6);
    check("t2_err", err, 1);
    check("t2_err_code", err_code, 3'd1);
    check("t2_in_ready", in_ready, 0);
    check("t2_jpeg_valid", jpeg_valid, 0);

    // 3: fill bytes ahead of DQT marker
    do_reset();
    word_q = '{32'hFFD8FFFF, 32'hFFDB0003, 32'h55FFDA00, 32'h03660000};
    push_exp(3'd2, 1'b1, 8'h55);
    push_exp(3'd5, 1'b1, 8'h66);
    run_until_done("t3_done", 60);
    check("t3_exp_drained", exp_q.size(), 0);
    check("t3_err", err, 0);

    // 4: APP1 skipped by length, then DHT and SOS
    do_reset();
    word_q = '{32'hFFD8FFE1, 32'h00051122, 32'h33FFC400, 32'h0377FFDA, 32'h00038800};
    push_exp(3'd3, 1'b1, 8'h77);
    push_exp(3'd5, 1'b1, 8'h88);
    run_until_done("t4_done", 60);
    check("t4_exp_drained", exp_q.size(), 0);
    check("t4_found_app0", found_app0, 0);

    // 5: 6-byte DHT payload with seg_ready toggling
    do_reset();
    rdy_mode = 1;
    word_q = '{32'hFFD8FFC4, 32'h00080102, 32'h03040506, 32'hFFDA0003, 32'h09000000};
    for (int i = 1; i <= 6; i++) push_exp(3'd3, i == 6, 8'(i));
    push_exp(3'd5, 1'b1, 8'h09);
    run_until_done("t5_done", 100);
    check("t5_exp_drained", exp_q.size(), 0);
    check("t5_words_used", word_q.size(), 0);

    // 6: unsupported SOF2
    do_reset();
    word_q = '{32'hFFD8FFC2, 32'h00110000};
    run(10);
    check("t6_err_code", err_code, 3'd3);
    check("t6_err", err, 1);
    check("t6_seg_valid", seg_valid, 0);

    // 7: EOI before SOS
    do_reset();
    word_q = '{32'hFFD8FFD9};
    run(10);
    check("t7_err_code", err_code, 3'd4);
    check("t7_state_err", dbg_state, 4'd9);

    // 8: reset in the middle of a stalled DQT payload
    do_reset();
    rdy_mode = 2;
    word_q = '{32'hFFD8FFDB, 32'h00100102, 32'h03040506};
    run(12);
    check("t8_stalled_valid", seg_valid, 1);
    check("t8_stalled_beat", {seg_type, seg_last, seg_byte}, {3'd2, 1'b0, 8'h01});
    check("t8_jpeg_valid", jpeg_valid, 1);
    check("t8_in_ready_full", in_ready, 0);
    rst = 1'b1;
    word_q.delete();
    run(1);
    check_all_zero("t8_abort_zero");
    rst = 1'b0;
    rdy_mode = 0;
    word_q = '{32'hFFD80000};
    run(8);
    check("t8_fresh_soi", jpeg_valid, 1);
    check("t8_fresh_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
